rmii_game_rx: RTL and testbench

Receive-side frame deframer for the two-board kart link. It sits in the 50 MHz Ethernet clock domain between the PHY's RMII pins and the clock-crossing buffer that feeds the game logic. It is the counterpart of the transmit framer: it detects preamble/SFD, assembles bytes from dibits, and filters on destination MAC and EtherType. It checks the FCS, extracts the 44-bit opponent-state word, and presents it with a one-cycle valid strobe.

---
 rtl/rmii_game_rx.sv | 211 +++++++++++++++++++++
 tb/tb_rmii_game_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rmii_game_rx.sv
// rmii_game_rx - RMII receive deframer for the kart link.
//
// Detects preamble/SFD, assembles bytes from dibits (LSB first), filters on
// destination MAC (or broadcast), EtherType, length and byte alignment, and
// extracts the 44-bit opponent-state word from payload bytes 14..19.
//
// Optional feature: define RX_CRC_CHECK_EN to build the CRC-32 datapath and
// reject frames whose residue is not 32'hDEBB20E3.
//
// Ports:
//   eth_clk     in   1  50 MHz RMII reference clock
//   eth_rst     in   1  synchronous active-high reset
//   eth_crsdv   in   1  RMII carrier-sense / data-valid
//   eth_rxd     in   2  RMII receive dibit
//   axiov       out  1  one-cycle strobe, new accepted word on axiod
//   axiod       out 44  last accepted opponent-state word
//   drop        out  1  one-cycle strobe, frame discarded
//   good_count  out 16  accepted frame count (wraps)
module rmii_game_rx #(
   parameter logic [47:0] MAC_ADDR  = 48'h02_00_00_00_00_02,
   parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
   input  logic        eth_clk,
   input  logic        eth_rst,
   input  logic        eth_crsdv,
   input  logic [1:0]  eth_rxd,
   output logic        axiov,
   output logic [43:0] axiod,
   output logic        drop,
   output logic [15:0] good_count
);

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      PREAMBLE,
      DATA,
      CHECK
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  pre_cnt_q, pre_cnt_d;
   logic [1:0]  phase_q, phase_d;
   logic [10:0] byte_cnt_q, byte_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [47:0] dest_q, dest_d;
   logic [15:0] type_q, type_d;
   logic [43:0] pay_q, pay_d;
   logic        axiov_q, axiov_d;
   logic        drop_q, drop_d;
   logic [43:0] axiod_q, axiod_d;
   logic [15:0] good_q, good_d;

   logic [7:0]  byte_nx;
   logic        crc_ok;
   logic        frame_ok;

   // Byte as it will look once the current dibit is shifted in.
   assign byte_nx = {eth_rxd, shift_q[7:2]};

`ifdef RX_CRC_CHECK_EN
   logic [31:0] crc_q, crc_d;

   function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
      logic [31:0] r;
      r = c;
      for (int unsigned i = 0; i < 2; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   always_comb begin
      crc_d = crc_q;
      if (state_q == PREAMBLE && state_d == DATA) crc_d = '1;
      else if (state_q == DATA && eth_crsdv)      crc_d = crc_dibit(crc_q, eth_rxd);
   end

   always_ff @(posedge eth_clk) begin
      if (eth_rst) crc_q <= '1;
      else         crc_q <= crc_d;
   end

   assign crc_ok = (crc_q == 32'hDEBB20E3);
`else
   assign crc_ok = 1'b1;
`endif

   assign frame_ok = ((dest_q == MAC_ADDR) || (dest_q == '1)) &&
                     (type_q == ETHERTYPE) &&
                     (byte_cnt_q >= 11'd64) && (byte_cnt_q <= 11'd1518) &&
                     (phase_q == 2'd0) && crc_ok;

   always_comb begin
      state_d    = state_q;
      pre_cnt_d  = pre_cnt_q;
      phase_d    = phase_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      dest_d     = dest_q;
      type_d     = type_q;
      pay_d      = pay_q;
      axiov_d    = 1'b0;
      drop_d     = 1'b0;
      axiod_d    = axiod_q;
      good_d     = good_q;

      unique case (state_q)
         WAIT_IDLE: begin
            if (!eth_crsdv) state_d = IDLE;
         end
         IDLE: begin
            if (eth_crsdv) begin
               if (eth_rxd == 2'b01) begin
                  state_d   = PREAMBLE;
                  pre_cnt_d = 3'd1;
               end else begin
                  state_d = WAIT_IDLE;
               end
            end
         end
         PREAMBLE: begin
            if (!eth_crsdv) begin
               state_d = IDLE;
            end else begin
               unique case (eth_rxd)
                  2'b01: if (pre_cnt_q != 3'd7) pre_cnt_d = pre_cnt_q + 3'd1;
                  2'b11: begin
                     if (pre_cnt_q >= 3'd4) begin
                        state_d    = DATA;
                        phase_d    = 2'd0;
                        byte_cnt_d = '0;
                     end else begin
                        state_d = WAIT_IDLE;
                     end
                  end
                  default: state_d = WAIT_IDLE;
               endcase
            end
         end
         DATA: begin
            if (!eth_crsdv) begin
               state_d = CHECK;
            end else begin
               shift_d = byte_nx;
               phase_d = phase_q + 2'd1;
               if (phase_q == 2'd3) begin
                  if (byte_cnt_q != 11'd2047) byte_cnt_d = byte_cnt_q + 11'd1;
                  if (byte_cnt_q <= 11'd5)
                     dest_d = {dest_q[39:0], byte_nx};
                  else if (byte_cnt_q == 11'd12 || byte_cnt_q == 11'd13)
                     type_d = {type_q[7:0], byte_nx};
                  else if (byte_cnt_q >= 11'd14 && byte_cnt_q <= 11'd18)
                     pay_d = {pay_q[35:0], byte_nx};
                  else if (byte_cnt_q == 11'd19)
                     // Only the high nibble of the last payload byte is kept.
                     pay_d = {pay_q[39:0], byte_nx[7:4]};
               end
            end
         end
         CHECK: begin
            state_d = IDLE;
            if (frame_ok) begin
               axiov_d = 1'b1;
               axiod_d = pay_q;
               good_d  = good_q + 16'd1;
            end else begin
               drop_d = 1'b1;
            end
         end
         default: state_d = WAIT_IDLE;
      endcase
   end

   always_ff @(posedge eth_clk) begin
      if (eth_rst) begin
         state_q    <= WAIT_IDLE;
         pre_cnt_q  <= '0;
         phase_q    <= '0;
         byte_cnt_q <= '0;
         shift_q    <= '0;
         dest_q     <= '0;
         type_q     <= '0;
         pay_q      <= '0;
         axiov_q    <= 1'b0;
         drop_q     <= 1'b0;
         axiod_q    <= '0;
         good_q     <= '0;
      end else begin
         state_q    <= state_d;
         pre_cnt_q  <= pre_cnt_d;
         phase_q    <= phase_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         dest_q     <= dest_d;
         type_q     <= type_d;
         pay_q      <= pay_d;
         axiov_q    <= axiov_d;
         drop_q     <= drop_d;
         axiod_q    <= axiod_d;
         good_q     <= good_d;
      end
   end

   assign axiov      = axiov_q;
   assign drop       = drop_q;
   assign axiod      = axiod_q;
   assign good_count = good_q;

endmodule

// File: tb/tb_rmii_game_rx.sv
// tb_rmii_game_rx - self-checking bench for rmii_game_rx.
// Table-driven frames, hand-written corner sequences and randomized frames
// judged by a frame-level reference model (byte lists + CRC recomputation).
module tb_rmii_game_rx;

   localparam logic [47:0] MAC   = 48'h02_00_00_00_00_02;
   localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
   localparam logic [15:0] ETYPE = 16'h88B5;

   logic        eth_clk = 1'b0;
   logic        eth_rst = 1'b1;
   logic        eth_crsdv = 1'b0;
   logic [1:0]  eth_rxd = 2'b00;
   logic        axiov;
   logic [43:0] axiod;
   logic        drop;
   logic [15:0] good_count;

   rmii_game_rx #(.MAC_ADDR(MAC), .ETHERTYPE(ETYPE)) dut (
      .eth_clk    (eth_clk),
      .eth_rst    (eth_rst),
      .eth_crsdv  (eth_crsdv),
      .eth_rxd    (eth_rxd),
      .axiov      (axiov),
      .axiod      (axiod),
      .drop       (drop),
      .good_count (good_count)
   );

   always #10 eth_clk = ~eth_clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   int          m_cnt = 0;
   logic [43:0] m_axiod = '0;

   byte unsigned frame[$];

   typedef struct {
      logic [47:0] dest;
      logic [15:0] etype;
      logic [47:0] pay;
      int          len;
      bit          flip;
      bit          extra;
      bit          exp_acc;
      logic [43:0] exp_d;
   } vec_t;

   vec_t tab[11];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] crc_of(input int n);
      logic [31:0] c;
      c = '1;
      for (int i = 0; i < n; i++) begin
         c = c ^ {24'd0, frame[i]};
         for (int b = 0; b < 8; b++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic build(input logic [47:0] dest, input logic [15:0] et,
                        input logic [47:0] pay, input int len, input bit flip);
      logic [31:0] fcs;
      logic [47:0] src;
      src = 48'h02_00_00_00_00_01;
      frame.delete();
      for (int i = 0; i < 6; i++) frame.push_back(dest[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) frame.push_back(src[47-8*i -: 8]);
      frame.push_back(et[15:8]);
      frame.push_back(et[7:0]);
      for (int i = 0; i < 6; i++) frame.push_back(pay[47-8*i -: 8]);
      while (frame.size() < len - 4) frame.push_back(8'(frame.size() * 7));
      fcs = crc_of(frame.size());
      if (flip) fcs = fcs ^ 32'h0000_0001;
      for (int i = 0; i < 4; i++) frame.push_back(fcs[8*i +: 8]);
   endtask

   // Frame-level acceptance rule: whole-byte frame of legal size, addressed
   // to us, right type, and trailing FCS matching a CRC of the rest.
   function automatic bit model_accept(input logic [47:0] dest, input logic [15:0] et,
                                       input int len, input bit extra);
      bit ok;
      ok = (dest == MAC || dest == BCAST) && (et == ETYPE) &&
           (len >= 64) && (len <= 1518) && !extra;
`ifdef RX_CRC_CHECK_EN
      ok = ok && (crc_of(len - 4) ==
                  {frame[len-1], frame[len-2], frame[len-3], frame[len-4]});
`endif
      return ok;
   endfunction

   task automatic drive(input bit dv, input logic [1:0] d);
      @(negedge eth_clk);
      eth_crsdv = dv;
      eth_rxd   = d;
   endtask

   task automatic send_byte(input byte unsigned b);
      logic [7:0] v;
      v = b;
      for (int j = 0; j < 4; j++) drive(1'b1, v[2*j +: 2]);
   endtask

   task automatic send_frame(input bit extra, input logic [1:0] xd);
      for (int i = 0; i < 7; i++) send_byte(8'h55);
      send_byte(8'hD5);
      for (int i = 0; i < frame.size(); i++) send_byte(frame[i]);
      if (extra) drive(1'b1, xd);
   endtask

   // Drops carrier, then watches a bounded window for the result strobe.
   task automatic watch(input string tag, input bit exp_none, input bit exp_acc);
      int nv, nd, lat, both;
      nv = 0; nd = 0; lat = -1; both = 0;
      drive(1'b0, 2'b00);
      for (int k = 1; k <= 8; k++) begin
         @(negedge eth_clk);
         if (axiov) begin nv++; if (lat < 0) lat = k; end
         if (drop)  begin nd++; if (lat < 0) lat = k; end
         if (axiov && drop) both++;
      end
      if (exp_none) begin
         chk({tag, " axiov_count"}, 64'(nv), 64'd0);
         chk({tag, " drop_count"},  64'(nd), 64'd0);
      end else begin
         chk({tag, " axiov_count"}, 64'(nv), exp_acc ? 64'd1 : 64'd0);
         chk({tag, " drop_count"},  64'(nd), exp_acc ? 64'd0 : 64'd1);
         chk({tag, " latency"},     64'(lat), 64'd2);
      end
      chk({tag, " exclusive"},  64'(both), 64'd0);
      chk({tag, " axiod"},      64'(axiod), 64'(m_axiod));
      chk({tag, " good_count"}, 64'(good_count), 64'(m_cnt & 16'hFFFF));
   endtask

   initial begin
      bit crc_flip_acc;
`ifdef RX_CRC_CHECK_EN
      crc_flip_acc = 1'b0;
`else
      crc_flip_acc = 1'b1;
`endif
      tab[0]  = '{MAC,   ETYPE, 48'h5F02FC870A58, 64,   0, 0, 1,            44'h5F02FC870A5};
      tab[1]  = '{MAC,   ETYPE, 48'h5F02FC870A58, 64,   1, 0, crc_flip_acc, 44'h5F02FC870A5};
      tab[2]  = '{48'h020000000007, ETYPE, 48'h010203040506, 64, 0, 0, 0,  44'h5F02FC870A5};
      tab[3]  = '{BCAST, ETYPE, 48'h112233445566, 64,   0, 0, 1,            44'h11223344556};
      tab[4]  = '{MAC,   ETYPE, 48'h777777777777, 60,   0, 0, 0,            44'h11223344556};
      tab[5]  = '{MAC,   ETYPE, 48'h888888888888, 1522, 0, 0, 0,            44'h11223344556};
      tab[6]  = '{MAC,   ETYPE, 48'h999999999999, 64,   0, 1, 0,            44'h11223344556};
      tab[7]  = '{MAC,   16'h0800, 48'h121212121212, 64, 0, 0, 0,           44'h11223344556};
      tab[8]  = '{MAC,   ETYPE, 48'hAABBCCDDEEFF, 1518, 0, 0, 1,            44'hAABBCCDDEEF};
      tab[9]  = '{MAC,   ETYPE, 48'h343434343434, 63,   0, 0, 0,            44'hAABBCCDDEEF};
      tab[10] = '{BCAST, ETYPE, 48'h0F1E2D3C4B5A, 65,   0, 0, 1,            44'h0F1E2D3C4B5};

      // Reset state.
      repeat (3) @(negedge eth_clk);
      chk("reset axiov", 64'(axiov), 64'd0);
      chk("reset drop",  64'(drop), 64'd0);
      chk("reset axiod", 64'(axiod), 64'd0);
      chk("reset good_count", 64'(good_count), 64'd0);
      eth_rst = 1'b0;
      repeat (4) @(negedge eth_clk);

      // Table vectors.
      for (int v = 0; v < 11; v++) begin
         build(tab[v].dest, tab[v].etype, tab[v].pay, tab[v].len, tab[v].flip);
         send_frame(tab[v].extra, 2'b10);
         if (tab[v].exp_acc) begin
            m_cnt++;
            m_axiod = tab[v].pay[47:4];
         end
         chk($sformatf("tab%0d expected_word", v), 64'(m_axiod), 64'(tab[v].exp_d));
         watch($sformatf("tab%0d", v), 1'b0, tab[v].exp_acc);
         repeat (12) @(negedge eth_clk);
      end

      // Short preamble: only two 01 dibits before the SFD dibit.
      build(MAC, ETYPE, 48'h5F02FC870A58, 64, 0);
      drive(1'b1, 2'b01);
      drive(1'b1, 2'b01);
      drive(1'b1, 2'b11);
      for (int i = 0; i < frame.size(); i++) send_byte(frame[i]);
      watch("short_pre", 1'b1, 1'b0);
      repeat (12) @(negedge eth_clk);

      // Reset asserted at byte 10 while carrier stays high.
      build(MAC, ETYPE, 48'hDEADBEEF1234, 64, 0);
      for (int i = 0; i < 7; i++) send_byte(8'h55);
      send_byte(8'hD5);
      for (int i = 0; i < frame.size(); i++) begin
         logic [7:0] b;
         b = frame[i];
         for (int j = 0; j < 4; j++) begin
            drive(1'b1, b[2*j +: 2]);
            eth_rst = (i == 10 && j == 0);
         end
      end
      eth_rst = 1'b0;
      m_cnt   = 0;
      m_axiod = '0;
      watch("rst_mid", 1'b1, 1'b0);
      repeat (12) @(negedge eth_clk);

      build(MAC, ETYPE, 48'h5F02FC870A58, 64, 0);
      send_frame(1'b0, 2'b00);
      m_cnt   = 1;
      m_axiod = 44'h5F02FC870A5;
      watch("after_rst", 1'b0, 1'b1);
      repeat (12) @(negedge eth_clk);

      // Randomized frames against the reference model.
      for (int n = 0; n < 16; n++) begin
         logic [47:0] dest;
         logic [15:0] et;
         logic [63:0] rp;
         int          len, sel;
         bit          flip, extra, acc;
         sel = $urandom_range(0, 3);
         rp  = {$urandom, $urandom};
         dest = (sel == 0) ? MAC : (sel == 1) ? BCAST :
                (sel == 2) ? rp[63:16] : 48'h020000000007;
         et   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : ETYPE;
         rp   = {$urandom, $urandom};
         sel  = $urandom_range(0, 9);
         len  = (sel == 0) ? $urandom_range(1515, 1522) :
                (sel == 1) ? $urandom_range(58, 63) : $urandom_range(64, 90);
         flip  = ($urandom_range(0, 4) == 0);
         extra = ($urandom_range(0, 5) == 0);
         build(dest, et, rp[47:0], len, flip);
         acc = model_accept(dest, et, len, extra);
         send_frame(extra, 2'($urandom));
         if (acc) begin
            m_cnt++;
            m_axiod = rp[47:4];
         end
         watch($sformatf("rand%0d", n), 1'b0, acc);
         repeat (12) @(negedge eth_clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
